// File: rtl/digit_scan_ctrl.sv
// Purpose : 4-digit time-multiplexed display scan controller with frame-aligned, double-buffered value updates.
// Latency : sel/tick/load_ack registered (1 clk); digit/blank combinational from registered state; commit <= 4*PRESCALE clks.
// Backpr. : none; en=0 freezes the scan (loads still captured), back-to-back loads overwrite the pending value.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset
//   en       - scan enable; low freezes cnt/sel/act and suppresses tick
//   load     - one-cycle request to take a new display value
//   value    - new display value, nibble i belongs to digit i
//   load_ack - one-cycle pulse when a value is committed to the active register
//   sel      - current digit index, drives the 2-to-4 decoder
//   digit    - nibble of the active value at index sel
//   tick     - one-cycle pulse on every digit advance
//   blank    - leading-zero blank for the current digit
//
// Build option: define SCAN_BLANK_EN to enable leading-zero blanking; otherwise blank is tied to 0.

module digit_scan_ctrl #(
   parameter int unsigned PRESCALE = 4   // clock cycles per digit, 1..65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] value,
   output logic        load_ack,
   output logic [1:0]  sel,
   output logic [3:0]  digit,
   output logic        tick,
   output logic        blank
);

   localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);

   logic [15:0] cnt_q,  cnt_d;
   logic [1:0]  sel_q,  sel_d;
   logic [15:0] act_q,  act_d;
   logic [15:0] pend_q, pend_d;
   logic        pv_q,   pv_d;
   logic        tick_q, tick_d;
   logic        load_ack_q, load_ack_d;

   logic advance;
   logic frame_end;

   // An advance only happens while enabled; the last digit's advance closes the frame.
   assign advance   = en && (cnt_q == CNT_LAST);
   assign frame_end = advance && (sel_q == 2'd3);

   always_comb begin
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      act_d      = act_q;
      pend_d     = pend_q;
      pv_d       = pv_q;
      tick_d     = 1'b0;
      load_ack_d = 1'b0;

      // Prescaler and digit stepping.
      if (en) begin
         if (advance) begin
            cnt_d  = '0;
            sel_d  = sel_q + 2'd1;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end

      // Value handling. A load in the frame-closing cycle goes straight to
      // the active register so it is not delayed by a whole extra frame.
      if (frame_end) begin
         if (load) begin
            act_d = value;
         end else if (pv_q) begin
            act_d = pend_q;
         end
         pv_d       = 1'b0;
         load_ack_d = load | pv_q;
      end else if (load) begin
         pend_d = value;
         pv_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         sel_q      <= '0;
         act_q      <= '0;
         pend_q     <= '0;
         pv_q       <= 1'b0;
         tick_q     <= 1'b0;
         load_ack_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         act_q      <= act_d;
         pend_q     <= pend_d;
         pv_q       <= pv_d;
         tick_q     <= tick_d;
         load_ack_q <= load_ack_d;
      end
   end

   assign sel      = sel_q;
   assign tick     = tick_q;
   assign load_ack = load_ack_q;
   assign digit    = act_q[{sel_q, 2'b00} +: 4];

`ifdef SCAN_BLANK_EN
   // Blank when this digit and every more significant digit are zero;
   // the least significant digit always shows so a zero value reads "0".
   logic blank_c;

   always_comb begin
      blank_c = 1'b0;
      case (sel_q)
         2'd1:    blank_c = (act_q[15:4]  == 12'h000);
         2'd2:    blank_c = (act_q[15:8]  == 8'h00);
         2'd3:    blank_c = (act_q[15:12] == 4'h0);
         default: blank_c = 1'b0;
      endcase
   end

   assign blank = blank_c;
`else
   assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_digit_scan_ctrl.sv
module tb_digit_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        load;
   logic [15:0] value;
   logic        load_ack;
   logic [1:0]  sel;
   logic [3:0]  digit;
   logic        tick;
   logic        blank;

   int n_chk = 0;
   int n_err = 0;
   int ack_seen = 0;

   logic [15:0] exp_q[$];     // values expected to be committed, oldest first
   logic [15:0] cur_exp;      // value expected in the active register

   always #5 clk = ~clk;

   digit_scan_ctrl #(.PRESCALE(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .load     (load),
      .value    (value),
      .load_ack (load_ack),
      .sel      (sel),
      .digit    (digit),
      .tick     (tick),
      .blank    (blank)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic exp_blank(input logic [15:0] a, input logic [1:0] s);
`ifdef SCAN_BLANK_EN
      case (s)
         2'd1:    return a[15:4]  == 12'h000;
         2'd2:    return a[15:8]  == 8'h00;
         2'd3:    return a[15:12] == 4'h0;
         default: return 1'b0;
      endcase
`else
      return 1'b0;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle load; an uncommitted entry is superseded (last load wins).
   task automatic do_load(input logic [15:0] v);
      if (exp_q.size() != 0) exp_q[exp_q.size()-1] = v;
      else                   exp_q.push_back(v);
      load  = 1'b1;
      value = v;
      step();
      load  = 1'b0;
   endtask

   // Runs until the frame-closing advance, then lets the monitor sample it.
   task automatic wait_boundary();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(tick && sel == 2'd0) && n < 64);
      if (!(tick && sel == 2'd0)) chk("boundary_timeout", 0, 1);
      @(negedge clk);
      #1;
   endtask

   // Starting right after a frame boundary, checks one full frame of digits.
   task automatic check_frame(input string tag, input logic [15:0] v);
      for (int s = 0; s < 4; s++) begin
         chk({tag, "_sel"}, 32'(sel), 32'(s));
         chk({tag, "_digit"}, 32'(digit), 32'(v[4*s +: 4]));
         repeat (4) step();
      end
   endtask

   // Scoreboard side: each commit pops the next expected value, and the
   // displayed digit / blank are checked against it every cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         cur_exp = 16'h0000;
      end else begin
         if (load_ack) begin
            ack_seen++;
            if (exp_q.size() == 0) chk("ack_unexpected", 1, 0);
            else                   cur_exp = exp_q.pop_front();
         end
         chk("mon_digit", 32'(digit), 32'(cur_exp[{sel, 2'b00} +: 4]));
         chk("mon_blank", 32'(blank), 32'(exp_blank(cur_exp, sel)));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int a0;
      logic [15:0] v;
      logic [3:0]  bl_exp;

      rst_n = 1'b0;
      en    = 1'b0;
      load  = 1'b0;
      value = 16'h0000;
      step();
      step();

      // Reset state.
      chk("rst_sel", 32'(sel), 0);
      chk("rst_digit", 32'(digit), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_ack", 32'(load_ack), 0);
      chk("rst_blank", 32'(blank), 0);

      // Free-running scan: tick every 4 cycles, sel 0,1,2,3,0.
      rst_n = 1'b1;
      en    = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         chk("scan_tick", 32'(tick), 32'((k % 4) == 0));
         chk("scan_sel", 32'(sel), 32'((k / 4) % 4));
         chk("scan_ack", 32'(load_ack), 0);
      end

      // Load 1234 while sel=1; commit at the boundary.
      repeat (4) step();
      chk("l1_sel", 32'(sel), 1);
      a0 = ack_seen;
      do_load(16'h1234);
      chk("l1_old_digit", 32'(digit), 0);
      wait_boundary();
      chk("l1_ack", 32'(load_ack), 1);
      chk("l1_ack_cnt", 32'(ack_seen - a0), 1);
      v = 16'h1234;
      check_frame("l1", v);

      // Last load wins within a frame.
      a0 = ack_seen;
      do_load(16'hAAAA);
      do_load(16'h5555);
      wait_boundary();
      chk("lw_ack_cnt", 32'(ack_seen - a0), 1);
      v = 16'h5555;
      check_frame("lw", v);

      // Load exactly in the boundary cycle.
      repeat (15) step();
      chk("bp_pre_sel", 32'(sel), 3);
      a0 = ack_seen;
      do_load(16'hBEEF);
      chk("bp_ack", 32'(load_ack), 1);
      chk("bp_tick", 32'(tick), 1);
      chk("bp_sel", 32'(sel), 0);
      chk("bp_digit", 32'(digit), 32'hF);
      v = 16'hBEEF;
      check_frame("bp", v);
      @(negedge clk);
      #1;
      chk("bp_no_second_ack", 32'(ack_seen - a0), 1);

      // Enable dropped at cnt=2 for 10 cycles.
      repeat (2) step();
      en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("en_sel_hold", 32'(sel), 0);
         chk("en_tick_low", 32'(tick), 0);
      end
      en = 1'b1;
      step();
      chk("en_resume1_tick", 32'(tick), 0);
      step();
      chk("en_resume2_tick", 32'(tick), 1);
      chk("en_resume2_sel", 32'(sel), 1);
      wait_boundary();

      // Leading-zero blanking with 0050.
      do_load(16'h0050);
      wait_boundary();
`ifdef SCAN_BLANK_EN
      bl_exp = 4'b1100;
`else
      bl_exp = 4'b0000;
`endif
      v = 16'h0050;
      for (int s = 0; s < 4; s++) begin
         chk("bl_sel", 32'(sel), 32'(s));
         chk("bl_blank", 32'(blank), 32'(bl_exp[s]));
         chk("bl_digit", 32'(digit), 32'(v[4*s +: 4]));
         repeat (4) step();
      end

      // Reset mid-frame discards a pending value without an ack.
      repeat (5) step();
      do_load(16'h1111);
      rst_n = 1'b0;
      exp_q.delete();
      step();
      step();
      rst_n = 1'b1;
      chk("mr_sel", 32'(sel), 0);
      chk("mr_digit", 32'(digit), 0);
      chk("mr_ack", 32'(load_ack), 0);
      a0 = ack_seen;
      repeat (20) step();
      chk("mr_no_ack", 32'(ack_seen - a0), 0);
      chk("mr_digit_after", 32'(digit), 0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexed scan controller for a 4-digit display. Holds a 16-bit display value, steps a 2-bit digit index at a programmable rate, and presents the selected nibble. Sits directly upstream of the 2-to-4 one-hot decoder: `sel` drives the decoder input, `digit` feeds the segment encoder. New values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `PRESCALE`, 4: clock cycles per digit; legal range 1..65535; 16-bit internal counter.

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `en`  in  1  scan enable; low freezes the scan
- `load`  in  1  one-cycle request to update the display value
- `value`  in  16  new value; nibble i belongs to digit i, so digit 0 is `value[3:0]`
- `load_ack`  out  1  one-cycle pulse when a value is committed to the active register
- `sel`  out  2  current digit index, drives the 2-to-4 decoder
- `digit`  out  4  nibble of the active value at index `sel`
- `tick`  out  1  one-cycle pulse on every digit advance
- `blank`  out  1  leading-zero blank for the current digit (see Configuration)

## Operation
- Registers:
  - `cnt`: 16-bit prescaler.
  - `sel`: 2-bit digit index.
  - `act`: 16-bit active value.
  - `pend`: 16-bit pending value, with valid flag `pv`.
  - `tick`, `load_ack`.
- Reset (`rst_n`=0 at a clock edge): `cnt`=0, `sel`=0, `act`=0, `pend`=0, `pv`=0, `tick`=0, `load_ack`=0. As a result `digit`=0 and `blank`=0. Reset overrides every other input.
- Prescaler, while `en`=1:
  - If `cnt`<PRESCALE-1, then `cnt`++.
  - If `cnt`==PRESCALE-1, this is an advance: `cnt`<=0, `sel`<=`sel`+1 (mod 4, so 3 wraps to 0), `tick`<=1.
- `tick` is 0 in every cycle that is not an advance.
- `en`=0: `cnt`, `sel` and `act` hold, and `tick`=0. Loads are still captured into `pend`.
- Frame boundary: an advance with `sel`==3.
- Load capture, outside a frame boundary: `load`=1 sets `pend`<=`value` and `pv`<=1. Back-to-back loads overwrite `pend`; the last one wins.
- Commit, at a frame boundary:
  - If `load`=1 in that same cycle, `act`<=`value` directly, bypassing `pend`.
  - Otherwise, if `pv`=1, `act`<=`pend`.
  - In either case, `pv`<=0 and `load_ack`<=1.
  - With no load and `pv`=0, `act` holds and `load_ack`=0.
- `digit` is combinational from registered state: `act[4*sel+3 -: 4]`.

## Timing
- PRESCALE=P, `en`=1 from reset release:
  - First `tick` occurs P cycles after release, with `sel`=1.
  - One frame is 4P cycles.
- `tick`, `load_ack` and the new `sel` all become visible after the same clock edge.
- Commit latency: a value loaded in any cycle appears on `digit` starting at the next frame boundary, i.e. when `sel` returns to 0. Worst case is 4P cycles.
- P=1: `sel` advances every enabled cycle and `tick` stays high continuously.
- `en` dropped mid-digit: the partial count is preserved, and the advance resumes after the remaining cycles once `en` returns high.
- Reset mid-frame discards `pend`/`pv`; no `load_ack` is issued for the lost value.

## Configuration
- `SCAN_BLANK_EN` defined: `blank`=1 when `sel`!=0 and the nibbles of `act` at index `sel` and every higher index are all zero. `blank` is combinational from `act` and `sel`. Digit 0 is never blanked.
- Not defined: the `blank` port still exists and is tied to 0.

## Test plan
- Reset then `en`=1, P=4: `tick` pulses every 4 cycles, and `sel` runs 0,1,2,3,0. After reset, `digit`=0 and `load_ack`=0.
- Value with commit at the boundary:
  - Stimulus: `load` `value`=16'h1234 while `sel`=1.
  - Before the boundary: `digit` shows the old value.
  - At the boundary: `load_ack` pulses once.
  - Next frame: `digit` reads 4,3,2,1 for `sel`=0..3.
- Last load wins: `load` 16'hAAAA and then 16'h5555 in the same frame gives a single `load_ack`, and `act`=16'h5555.
- Load exactly in the boundary cycle with 16'hBEEF: `act`=16'hBEEF immediately, `load_ack`=1, `pv`=0.
- `en` low for 10 cycles at `cnt`=2 (P=4): `sel` and `tick` are frozen; the next `tick` comes 2 enabled cycles after `en` returns.
- `SCAN_BLANK_EN`, `act`=16'h0050: `blank` is 0,0,1,1 for `sel`=0..3. With the macro undefined, `blank` is always 0.
